// File: rtl/lane_rr_arbiter.sv
// lane_rr_arbiter: round-robin arbiter that loads one registered (a, b) output slot
// from NUM_LANES requesters, with burst-limited hold. Define LANE_MASK_EN to add i_lane_mask.
module lane_rr_arbiter #(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 1,
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_LANES-1:0]        i_req,
  input  logic [NUM_LANES*DATA_W-1:0] i_a,
  input  logic [NUM_LANES*DATA_W-1:0] i_b,
`ifdef LANE_MASK_EN
  input  logic [NUM_LANES-1:0]        i_lane_mask,
`endif
  output logic [NUM_LANES-1:0]        o_gnt,
  output logic                        o_valid,
  output logic [DATA_W-1:0]           o_a,
  output logic [DATA_W-1:0]           o_b,
  output logic [LANE_W-1:0]           o_lane,
  input  logic                        i_ready,
  output logic                        o_dbg_state
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  // Handshake: a lane transfers when i_req[k] & o_gnt[k]; the shared word is
  // consumed when o_valid & i_ready, and may be replaced in that same cycle.
  typedef enum logic { S_EMPTY = 1'b0, S_FULL = 1'b1 } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LANE_W-1:0]   ptr_q, ptr_d;
  logic [LANE_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_LANES-1:0] lane_mask;
  logic [NUM_LANES-1:0] elig;
  logic [NUM_LANES-1:0] above;
  logic                 slot_free;
  logic                 hold;
  logic                 grant_en;
  logic [LANE_W-1:0]    search_lane;
  logic [LANE_W-1:0]    gnt_lane;

`ifdef LANE_MASK_EN
  assign lane_mask = i_lane_mask;
`else
  assign lane_mask = '1;
`endif

  function automatic logic [LANE_W-1:0] lowest_set(input logic [NUM_LANES-1:0] v);
    lowest_set = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (v[k]) lowest_set = LANE_W'(k);
    end
  endfunction

  always_comb begin
    elig      = i_req & lane_mask;
    slot_free = (state_q == S_EMPTY) | i_ready;
    hold      = elig[last_q] & (cnt_q != BURST_LAST);
    // Two-pass search: lanes at or above ptr first, then wrap to the lowest eligible lane.
    for (int k = 0; k < NUM_LANES; k++) begin
      above[k] = elig[k] & (LANE_W'(k) >= ptr_q);
    end
    search_lane = lowest_set((|above) ? above : elig);
    grant_en    = ~i_rst & slot_free & (|elig);
    gnt_lane    = hold ? last_q : search_lane;
    o_gnt       = grant_en ? (NUM_LANES'(1) << gnt_lane) : '0;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (grant_en) begin
      state_d = S_FULL;
      a_d     = i_a[int'(gnt_lane)*DATA_W +: DATA_W];
      b_d     = i_b[int'(gnt_lane)*DATA_W +: DATA_W];
      lane_d  = gnt_lane;
      if (hold) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // Re-finding the current lane through the search keeps its count saturated.
        cnt_d  = (search_lane == last_q) ? cnt_q : '0;
        last_d = search_lane;
        ptr_d  = (search_lane == LANE_W'(NUM_LANES - 1)) ? '0 : search_lane + 1'b1;
      end
    end else if ((state_q == S_FULL) && i_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      lane_q  <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lane_q  <= lane_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid     = (state_q == S_FULL);
  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_lane      = lane_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Bench for lane_rr_arbiter: two instances (MAX_BURST 1 and 4) on shared inputs,
// each checked against a lane-search reference model; scoreboard on the burst-1 output.
module tb_lane_rr_arbiter;

  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  req = 8'h00;
  logic [63:0] a_bus = '0;
  logic [63:0] b_bus = '0;
  logic        ready = 1'b0;
  logic [7:0]  mask_v = 8'hFF;

  logic [7:0] gnt1, gnt4, a1, a4, b1, b4;
  logic [2:0] lane1, lane4;
  logic       valid1, valid4, dbg1, dbg4;

  always #5 clk = ~clk;

  lane_rr_arbiter #(.NUM_LANES(8), .DATA_W(8), .MAX_BURST(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_a(a_bus), .i_b(b_bus),
`ifdef LANE_MASK_EN
    .i_lane_mask(mask_v),
`endif
    .o_gnt(gnt1), .o_valid(valid1), .o_a(a1), .o_b(b1), .o_lane(lane1),
    .i_ready(ready), .o_dbg_state(dbg1)
  );

  lane_rr_arbiter #(.NUM_LANES(8), .DATA_W(8), .MAX_BURST(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_a(a_bus), .i_b(b_bus),
`ifdef LANE_MASK_EN
    .i_lane_mask(mask_v),
`endif
    .o_gnt(gnt4), .o_valid(valid4), .o_a(a4), .o_b(b4), .o_lane(lane4),
    .i_ready(ready), .o_dbg_state(dbg4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = burst-1 instance, index 1 = burst-4 instance.
  int         bursts[2] = '{1, 4};
  logic       mv[2];
  logic [7:0] ma[2], mbv[2], eg[2];
  int         mlane[2], mp[2], ml[2], mc[2];
  logic [28:0] obs[2], expv[2];
  logic [18:0] exp_q[$];

  function automatic logic [7:0] model_gnt(int u);
    logic [7:0] elig;
    int k;
    if (rst) return 8'h00;
    elig = req & mask_v;
    if ((mv[u] && !ready) || elig == 8'h00) return 8'h00;
    if (elig[ml[u]] && mc[u] < bursts[u] - 1) return 8'h01 << ml[u];
    for (int off = 0; off < NL; off++) begin
      k = (mp[u] + off) % NL;
      if (elig[k]) return 8'h01 << k;
    end
    return 8'h00;
  endfunction

  task automatic m_commit();
    int k;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        mv[u] = 1'b0; ma[u] = 8'h00; mbv[u] = 8'h00;
        mlane[u] = 0; mp[u] = 0; ml[u] = 0; mc[u] = 0;
        if (u == 0) exp_q.delete();
      end else if (eg[u] != 8'h00) begin
        k = $clog2(eg[u]);
        if (k == ml[u] && mc[u] < bursts[u] - 1) mc[u]++;
        else begin
          if (k != ml[u]) mc[u] = 0;
          ml[u] = k;
          mp[u] = (k + 1) % NL;
        end
        mv[u] = 1'b1;
        ma[u] = a_bus[k*8 +: 8];
        mbv[u] = b_bus[k*8 +: 8];
        mlane[u] = k;
        if (u == 0) exp_q.push_back({3'(k), a_bus[k*8 +: 8], b_bus[k*8 +: 8]});
      end else if (ready) begin
        mv[u] = 1'b0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      eg[u]   = model_gnt(u);
      expv[u] = {eg[u], mv[u], mv[u], ma[u], mbv[u], 3'(mlane[u])};
    end
    obs[0] = {gnt1, valid1, dbg1, a1, b1, lane1};
    obs[1] = {gnt4, valid4, dbg4, a4, b4, lane4};
  endtask

  task automatic advance();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; ready = 1'b0;
    advance();
    advance();
    sample();
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (obs[u] !== 29'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d got %h exp %h", u, obs[u], 29'h0);
      end
    end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_single();
    a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
    a_bus[3*8 +: 8] = 8'h5A; b_bus[3*8 +: 8] = 8'hA5;
    req = 8'h08; ready = 1'b1;
    sample();
    n_checks++;
    if (obs[0][28:21] !== 8'h08) begin
      n_fail++; $display("FAIL single_gnt got %h exp 08", obs[0][28:21]);
    end
    advance();
    req = 8'h00;
    sample();
    n_checks++;
    if (obs[0] !== {8'h00, 1'b1, 1'b1, 8'h5A, 8'hA5, 3'd3}) begin
      n_fail++; $display("FAIL single_word got %h", obs[0]);
    end
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (obs[u] !== expv[u]) begin
        n_fail++; $display("FAIL single_model dut%0d got %h exp %h", u, obs[u], expv[u]);
      end
    end
    advance();
    sample();
    n_checks++;
    if (obs[0][20] !== 1'b0 || obs[1][20] !== 1'b0) begin
      n_fail++; $display("FAIL single_drop got %b%b exp 00", obs[0][20], obs[1][20]);
    end
    advance();
  endtask

  task automatic test_round_robin();
    do_reset();
    a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
    req = 8'hFF; ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      sample();
      if (i >= 1) begin
        n_checks++;
        if (obs[0][2:0] !== 3'((i - 1) % 8) || obs[0][20] !== 1'b1) begin
          n_fail++; $display("FAIL rr_seq cyc%0d got lane %0d valid %b exp lane %0d", i, obs[0][2:0], obs[0][20], (i - 1) % 8);
        end
      end
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (obs[u] !== expv[u]) begin
          n_fail++; $display("FAIL rr_model dut%0d cyc%0d got %h exp %h", u, i, obs[u], expv[u]);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [2:0] held;
    req = 8'hFF; ready = 1'b0;
    held = lane1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) ready = 1'b1;
      sample();
      if (i < 3) begin
        n_checks++;
        if (obs[0][28:21] !== 8'h00 || obs[0][2:0] !== held) begin
          n_fail++; $display("FAIL stall cyc%0d got gnt %h lane %0d exp gnt 00 lane %0d", i, obs[0][28:21], obs[0][2:0], held);
        end
      end
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (obs[u] !== expv[u]) begin
          n_fail++; $display("FAIL stall_model dut%0d cyc%0d got %h exp %h", u, i, obs[u], expv[u]);
        end
      end
      advance();
    end
  endtask

  task automatic test_burst_reset();
    int seq4[9] = '{2, 2, 2, 2, 5, 5, 5, 5, 2};
    do_reset();
    req = 8'h24; ready = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      sample();
      if (i >= 1) begin
        n_checks++;
        if (obs[1][2:0] !== 3'(seq4[i - 1])) begin
          n_fail++; $display("FAIL burst_seq cyc%0d got lane %0d exp %0d", i, obs[1][2:0], seq4[i - 1]);
        end
      end
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (obs[u] !== expv[u]) begin
          n_fail++; $display("FAIL burst_model dut%0d cyc%0d got %h exp %h", u, i, obs[u], expv[u]);
        end
      end
      advance();
    end
    rst = 1'b1;
    sample();
    n_checks++;
    if (obs[0][28:21] !== 8'h00 || obs[1][28:21] !== 8'h00) begin
      n_fail++; $display("FAIL rst_gnt got %h %h exp 00 00", obs[0][28:21], obs[1][28:21]);
    end
    advance();
    rst = 1'b0;
    sample();
    n_checks++;
    if (obs[1][20] !== 1'b0 || obs[1][28:21] !== 8'h04) begin
      n_fail++; $display("FAIL rst_restart got valid %b gnt %h exp valid 0 gnt 04", obs[1][20], obs[1][28:21]);
    end
    advance();
  endtask

`ifdef LANE_MASK_EN
  task automatic test_mask();
    do_reset();
    mask_v = 8'hF0; req = 8'hFF; ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      sample();
      n_checks++;
      if ((obs[0][24:21] | obs[1][24:21]) !== 4'h0) begin
        n_fail++; $display("FAIL mask_low cyc%0d got %h %h exp low nibble 0", i, obs[0][28:21], obs[1][28:21]);
      end
      if (i >= 1) begin
        n_checks++;
        if (obs[0][2:0] !== 3'(4 + (i - 1) % 4)) begin
          n_fail++; $display("FAIL mask_seq cyc%0d got lane %0d exp %0d", i, obs[0][2:0], 4 + (i - 1) % 4);
        end
      end
      advance();
    end
    mask_v = 8'hFF;
  endtask
`endif

  task automatic test_random();
    logic [18:0] got, want;
    do_reset();
    req = 8'h00;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NL; k++) begin
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          a_bus[k*8 +: 8] = 8'($urandom);
          b_bus[k*8 +: 8] = 8'($urandom);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
`ifdef LANE_MASK_EN
      mask_v = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
`endif
      sample();
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (obs[u] !== expv[u]) begin
          n_fail++; $display("FAIL rand_model dut%0d cyc%0d got %h exp %h", u, i, obs[u], expv[u]);
        end
      end
      if (valid1 && ready) begin
        got = {lane1, a1, b1};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        n_checks++;
        if (got !== want) begin
          n_fail++; $display("FAIL rand_sb cyc%0d got %h exp %h", i, got, want);
        end
      end
      advance();
      req = req & ~eg[0];
    end
    req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_burst_reset();
`ifdef LANE_MASK_EN
    test_mask();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
